mem_map_ctrl: RTL and testbench
===============================

MEM_MAP_CTRL -- requirements
Module: mem_map_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: word width in bits.
REQ-002 SHALL have parameter WORD_AW, default 3: word-address bits per bank (DEPTH = 2**WORD_AW).
REQ-003 SHALL have parameter BANK_AW, default 3: bank-index bits; ADDR_W = BANK_AW+WORD_AW.
REQ-004 SHALL have parameter N_ROM, default 2: ROM banks, occupying bank indices 0..N_ROM-1.
REQ-005 SHALL have parameter N_RAM, default 4: SRAM banks, occupying indices N_ROM..N_ROM+N_RAM-1; N_ROM+N_RAM <= 2**BANK_AW.
REQ-006 Ports (clock and reset first):
 clk  in  1  single clock, all logic on rising edge
 rst_n  in  1  reset, synchronous, active-low
 req  in  1  request strobe
 we  in  1  1=write, 0=read, sampled with req
 addr  in  ADDR_W  {bank index, word index}
 din  in  DATA_W  write data
 ready  out  1  request accepted when req&&ready
 rsp_valid  out  1  one-cycle response pulse
 dout  out  DATA_W  read data, valid with rsp_valid
 err  out  1  error flag, valid with rsp_valid
 err_cnt  out  8  saturating error counter

Function
REQ-007 FSM states SHALL be INIT and RUN only.
REQ-008 In INIT, ready=0 and a counter SHALL write 0 to one SRAM word per cycle, sweeping all N_RAM*DEPTH words in ascending order, then move to RUN on the cycle after the last word.
REQ-009 In RUN, ready SHALL be 1 every cycle (fully pipelined, one request per cycle).
REQ-010 A request is accepted only when req&&ready; req while ready=0 SHALL be ignored with no response.
REQ-011 Accepted request in cycle N SHALL produce rsp_valid=1 with dout/err in cycle N+1 (latency 1); rsp_valid=0 otherwise.
REQ-012 Read of ROM bank b, word k SHALL return F(b*DEPTH+k) mod 2**DATA_W, with F(0)=F(1)=1, F(i)=F(i-1)+F(i-2); err=0.
REQ-013 Read of an SRAM word SHALL return its stored value; err=0.
REQ-014 Write to an SRAM word SHALL store din at the clock edge of acceptance; response dout=0, err=0.
REQ-015 Write to a ROM bank SHALL NOT alter contents; response dout=0, err=1.
REQ-016 Any access with bank index >= N_ROM+N_RAM SHALL respond dout=0, err=1, no state change.
REQ-017 Read accepted in the cycle after a write to the same address SHALL return the new data.
REQ-018 err_cnt SHALL increment by 1 on each err=1 response and saturate at 255.
REQ-019 dout SHALL be 0 whenever rsp_valid=0.

Reset
REQ-020 rst_n=0 at a rising edge SHALL force state=INIT, init counter=0, ready=0, rsp_valid=0, dout=0, err=0, err_cnt=0.
REQ-021 Reset mid-RUN SHALL drop any pending response and SHALL re-run the full INIT sweep after release.
REQ-022 Reset during INIT SHALL restart the sweep from word 0.

Structure
REQ-023 Package mem_map_pkg SHALL hold the state encoding (INIT, RUN) and the err_cnt width/saturation constant.
REQ-024 Each SRAM bank SHALL be an instance of sub-module mem_bank (DATA_W x DEPTH, sync write, async read), generated N_RAM times; ROM contents SHALL be computed at elaboration, not hand-listed.

Verification (defaults: DATA_W=8, WORD_AW=3, BANK_AW=3, N_ROM=2, N_RAM=4)
REQ-025 Release reset, req=1 throughout -> ready=0 for exactly 32 cycles, no rsp_valid; ready=1 on cycle 33; then read addr 6'o20 -> dout=0, err=0.
REQ-026 Read addr 0,7,13 back-to-back -> rsp_valid three consecutive cycles, dout=1,21,121, err=0.
REQ-027 Write 0xA5 to addr 6'o23, read 6'o23 next cycle -> write rsp dout=0 err=0; read rsp dout=0xA5.
REQ-028 Write 0xFF to addr 5 -> err=1, err_cnt=1; read addr 5 -> dout=8, err=0.
REQ-029 Read addr 6'o60 (bank 6) 300 times -> each err=1, dout=0; err_cnt stops at 255.
REQ-030 Write 0x3C to 6'o21, assert rst_n=0 one cycle with read of 6'o21 pending -> no rsp_valid; after 32-cycle INIT, read 6'o21 -> 0x00, err_cnt=0.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared definitions for the banked ROM/SRAM memory-map controller.
package mem_map_pkg;

   // Controller phases: zero-fill sweep after reset, then normal service
   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int unsigned ERR_CNT_W = 8;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage : mem_map_pkg

// File: rtl/mem_bank.sv
// Single SRAM bank: synchronous write, asynchronous (combinational) read.
module mem_bank #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned WORD_AW = 3
) (
   input  logic               clk,
   input  logic               we_i,
   input  logic [WORD_AW-1:0] waddr_i,
   input  logic [DATA_W-1:0]  wdata_i,
   input  logic [WORD_AW-1:0] raddr_i,
   output logic [DATA_W-1:0]  rdata_o
);

   localparam int unsigned DEPTH = 2 ** WORD_AW;

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Storage array write port
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : mem_bank

// File: rtl/mem_map_ctrl.sv
// Memory-map controller: Fibonacci ROM banks below N_ROM, SRAM banks above,
// zero-fill sweep after reset, one request per cycle with a 1-cycle response.
module mem_map_ctrl
   import mem_map_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned WORD_AW = 3,
   parameter int unsigned BANK_AW = 3,
   parameter int unsigned N_ROM   = 2,
   parameter int unsigned N_RAM   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req,
   input  logic                          we,
   input  logic [BANK_AW+WORD_AW-1:0]    addr,
   input  logic [DATA_W-1:0]             din,
   output logic                          ready,
   output logic                          rsp_valid,
   output logic [DATA_W-1:0]             dout,
   output logic                          err,
   output logic [ERR_CNT_W-1:0]          err_cnt
);

   localparam int unsigned ADDR_W    = BANK_AW + WORD_AW;
   localparam int unsigned DEPTH     = 2 ** WORD_AW;
   localparam int unsigned ROM_WORDS = N_ROM * DEPTH;
   localparam int unsigned RAM_WORDS = N_RAM * DEPTH;
   localparam int unsigned INIT_W    = $clog2(RAM_WORDS + 1);
   localparam int unsigned IB_W      = INIT_W - WORD_AW;
   localparam int unsigned BANK_W1   = BANK_AW + 1;

   localparam logic [INIT_W-1:0]  INIT_LAST = INIT_W'(RAM_WORDS - 1);
   localparam logic [BANK_AW:0]   ROM_END   = BANK_W1'(N_ROM);
   localparam logic [BANK_AW:0]   RAM_END   = BANK_W1'(N_ROM + N_RAM);

   // Fibonacci word for linear ROM index idx, wrapped to DATA_W bits
   function automatic logic [DATA_W-1:0] rom_word(input int unsigned idx);
      logic [DATA_W-1:0] f_prev;
      logic [DATA_W-1:0] f_cur;
      logic [DATA_W-1:0] f_next;
      f_prev = DATA_W'(1);
      f_cur  = DATA_W'(1);
      for (int unsigned i = 2; i <= idx; i++) begin
         f_next = f_prev + f_cur;
         f_prev = f_cur;
         f_cur  = f_next;
      end
      return f_cur;
   endfunction

   state_e               state_q;
   logic [INIT_W-1:0]    init_cnt_q;
   logic                 ready_q;
   logic                 rsp_valid_q;
   logic [DATA_W-1:0]    dout_q;
   logic                 err_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;
   logic [ERR_CNT_W-1:0] err_cnt_d;

   logic [BANK_AW-1:0]   bank_c;
   logic [WORD_AW-1:0]   word_c;
   logic                 is_rom_c;
   logic                 is_ram_c;
   logic                 accept_c;
   logic                 init_en_c;
   logic [IB_W-1:0]      init_bank_c;
   logic [WORD_AW-1:0]   init_word_c;
   logic [WORD_AW-1:0]   ram_waddr_c;
   logic [DATA_W-1:0]    ram_wdata_c;
   logic [N_RAM-1:0]     ram_we_c;
   logic [DATA_W-1:0]    ram_rdata_c [N_RAM];
   logic [DATA_W-1:0]    rom_c [ROM_WORDS];
   logic [DATA_W-1:0]    rd_data_c;
   logic                 rsp_err_c;
   logic [DATA_W-1:0]    rsp_dout_c;

   assign bank_c      = addr[ADDR_W-1:WORD_AW];
   assign word_c      = addr[WORD_AW-1:0];
   assign is_rom_c    = {1'b0, bank_c} < ROM_END;
   assign is_ram_c    = !is_rom_c && ({1'b0, bank_c} < RAM_END);
   assign accept_c    = req && ready_q && rst_n;
   assign init_en_c   = (state_q == INIT) && rst_n;
   assign init_bank_c = init_cnt_q[INIT_W-1:WORD_AW];
   assign init_word_c = init_cnt_q[WORD_AW-1:0];
   assign ram_waddr_c = init_en_c ? init_word_c : word_c;
   assign ram_wdata_c = init_en_c ? '0 : din;

   // ROM image is a constant table built at elaboration
   for (genvar g = 0; g < ROM_WORDS; g++) begin : g_rom
      assign rom_c[g] = rom_word(g);
   end

   // SRAM banks; the init sweep owns the write port until RUN
   for (genvar g = 0; g < N_RAM; g++) begin : g_ram
      assign ram_we_c[g] = init_en_c ? (init_bank_c == IB_W'(g))
                                     : (accept_c && we && (bank_c == BANK_AW'(N_ROM + g)));
      mem_bank #(
         .DATA_W  (DATA_W),
         .WORD_AW (WORD_AW)
      ) u_bank (
         .clk     (clk),
         .we_i    (ram_we_c[g]),
         .waddr_i (ram_waddr_c),
         .wdata_i (ram_wdata_c),
         .raddr_i (word_c),
         .rdata_o (ram_rdata_c[g])
      );
   end

   // Read-data select across ROM words and SRAM banks, plus response decode
   always_comb begin
      rd_data_c = '0;
      for (int unsigned i = 0; i < ROM_WORDS; i++) begin
         if (is_rom_c && (addr == ADDR_W'(i))) begin
            rd_data_c = rom_c[i];
         end
      end
      for (int unsigned i = 0; i < N_RAM; i++) begin
         if (is_ram_c && (bank_c == BANK_AW'(N_ROM + i))) begin
            rd_data_c = ram_rdata_c[i];
         end
      end
      rsp_err_c  = !is_ram_c && !(is_rom_c && !we);
      rsp_dout_c = (!we && !rsp_err_c) ? rd_data_c : '0;
      err_cnt_d  = err_cnt_q;
      if (accept_c && rsp_err_c && (err_cnt_q != ERR_CNT_MAX)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   // Phase FSM, init sweep counter and registered response outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= INIT;
         init_cnt_q  <= '0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         dout_q      <= '0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         rsp_valid_q <= accept_c;
         dout_q      <= accept_c ? rsp_dout_c : '0;
         err_q       <= accept_c && rsp_err_c;
         err_cnt_q   <= err_cnt_d;
         if (state_q == INIT) begin
            ready_q <= 1'b0;
            if (init_cnt_q == INIT_LAST) begin
               state_q    <= RUN;
               ready_q    <= 1'b1;
               init_cnt_q <= '0;
            end else begin
               init_cnt_q <= init_cnt_q + INIT_W'(1);
            end
         end else begin
            ready_q <= 1'b1;
         end
      end
   end

   assign ready     = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign dout      = dout_q;
   assign err       = err_q;
   assign err_cnt   = err_cnt_q;

endmodule : mem_map_ctrl

// File: tb/tb_mem_map_ctrl.sv
// Scoreboard bench for mem_map_ctrl: directed scenarios plus random traffic.
module tb_mem_map_ctrl;

   localparam int N_ROM   = 2;
   localparam int N_RAM   = 4;
   localparam int DEPTH   = 8;
   localparam int N_BANKS = N_ROM + N_RAM;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req = 1'b0;
   logic       we = 1'b0;
   logic [5:0] addr = '0;
   logic [7:0] din = '0;
   logic       ready;
   logic       rsp_valid;
   logic [7:0] dout;
   logic       err;
   logic [7:0] err_cnt;

   always #5 clk = ~clk;

   mem_map_ctrl #(
      .DATA_W  (8),
      .WORD_AW (3),
      .BANK_AW (3),
      .N_ROM   (N_ROM),
      .N_RAM   (N_RAM)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .din       (din),
      .ready     (ready),
      .rsp_valid (rsp_valid),
      .dout      (dout),
      .err       (err),
      .err_cnt   (err_cnt)
   );

   typedef struct packed {
      logic [7:0] dout;
      logic       err;
      logic [7:0] cnt;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   int         checks = 0;
   int         errors = 0;
   bit         mon_en = 1'b0;
   logic [7:0] rom_m [N_ROM*DEPTH];
   logic [7:0] ram_m [N_RAM*DEPTH];
   int         err_m = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour: returns the expected response and updates model state
   function automatic exp_t model(input bit w, input logic [5:0] a, input logic [7:0] d);
      exp_t e;
      int bank = int'(a) / DEPTH;
      int word = int'(a) % DEPTH;
      e = '0;
      if (bank >= N_BANKS) begin
         e.err = 1'b1;
      end else if (bank < N_ROM) begin
         if (w) e.err = 1'b1;
         else   e.dout = rom_m[bank*DEPTH + word];
      end else begin
         if (w) ram_m[(bank-N_ROM)*DEPTH + word] = d;
         else   e.dout = ram_m[(bank-N_ROM)*DEPTH + word];
      end
      if (e.err && err_m < 255) err_m++;
      e.cnt = 8'(err_m);
      return e;
   endfunction

   task automatic issue(input bit w, input logic [5:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      req = 1'b1; we = w; addr = a; din = d;
      sb_q.push_back(model(w, a, d));
   endtask

   task automatic idle();
      @(posedge clk); #1;
      req = 1'b0; we = 1'b0;
   endtask

   // Counts not-ready cycles after release; the held read is taken on the first ready cycle
   task automatic init_wait();
      int  n = 0;
      bit  seen = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (ready === 1'b1) begin
            seen = 1'b1;
            break;
         end
         n++;
      end
      check("init_len", 32'(n), 32'd32);
      if (seen) sb_q.push_back(model(1'b0, 6'd0, 8'd0));
   endtask

   task automatic do_reset(input bit pend, input logic [5:0] pa);
      @(posedge clk); #1;
      rst_n = 1'b0; req = pend; we = 1'b0; addr = pa;
      @(posedge clk); #1;
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_errcnt", 32'(err_cnt), 32'd0);
      err_m = 0;
      for (int i = 0; i < N_RAM*DEPTH; i++) ram_m[i] = 8'd0;
      mon_en = 1'b1;
      rst_n = 1'b1; req = 1'b1; we = 1'b0; addr = '0;
      init_wait();
   endtask

   // Response monitor: pops the scoreboard whenever a response is presented
   always @(negedge clk) begin
      if (mon_en) begin
         if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_rsp actual=1 required=0 at %0t", $time);
            end else begin
               mon_e = sb_q.pop_front();
               check("rsp_dout", 32'(dout), 32'(mon_e.dout));
               check("rsp_err", 32'(err), 32'(mon_e.err));
               check("rsp_errcnt", 32'(err_cnt), 32'(mon_e.cnt));
            end
         end else begin
            check("idle_valid", 32'(rsp_valid), 32'd0);
            check("idle_dout", 32'(dout), 32'd0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0] ra;
      rom_m[0] = 8'd1;
      rom_m[1] = 8'd1;
      for (int i = 2; i < N_ROM*DEPTH; i++) rom_m[i] = rom_m[i-1] + rom_m[i-2];

      // Power-on: 32-cycle sweep with req held, then SRAM reads back zero
      do_reset(1'b0, 6'd0);
      issue(1'b0, 6'o20, 8'd0);

      // ROM reads back-to-back
      issue(1'b0, 6'd0, 8'd0);
      issue(1'b0, 6'd7, 8'd0);
      issue(1'b0, 6'd13, 8'd0);

      // Write then immediate read of the same SRAM word
      issue(1'b1, 6'o23, 8'hA5);
      issue(1'b0, 6'o23, 8'd0);

      // ROM write is rejected and leaves contents intact
      issue(1'b1, 6'd5, 8'hFF);
      issue(1'b0, 6'd5, 8'd0);
      idle();

      // Random traffic, including read-after-write pairs and unmapped banks
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 4))
            0: idle();
            1: begin
               ra = 6'($urandom_range(16, 47));
               issue(1'b1, ra, 8'($urandom));
               issue(1'b0, ra, 8'd0);
            end
            default: issue(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom));
         endcase
      end
      idle();

      // Unmapped bank hammering saturates the error counter
      for (int i = 0; i < 300; i++) issue(1'b0, 6'o60, 8'd0);
      idle();
      idle();
      @(negedge clk);
      check("errcnt_sat", 32'(err_cnt), 32'd255);

      // Reset in RUN with a read pending: response dropped, SRAM re-zeroed
      issue(1'b1, 6'o21, 8'h3C);
      do_reset(1'b1, 6'o21);
      issue(1'b0, 6'o21, 8'd0);
      idle();
      @(negedge clk);
      check("errcnt_after_rst", 32'(err_cnt), 32'd0);

      repeat (3) idle();
      @(negedge clk);
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mem_map_ctrl
